// File: rtl/ifu_pkg.sv
// Shared core constants and types for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 2;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } ifu_state_e;

  // One prefetch buffer entry: instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry synchronous prefetch buffer with flush and occupancy count.
module ifu_fifo
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // On a full buffer the write slot equals the read slot; popping frees it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues sequential fetches, buffers responses, handles redirects.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        ibus_req_valid_o,
  input  logic        ibus_req_ready_i,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_rsp_valid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  ifu_state_e   state_q;
  logic [31:0]  pc_q;
  logic [31:0]  last_pc_q;
  logic [31:0]  rsp_pc_q;
  logic [1:0]   outstanding_q;
  logic [1:0]   drop_cnt_q;

  logic         handshake;
  logic         drop_rsp;
  logic         push;
  logic         pop;
  logic [1:0]   fifo_count;
  logic [1:0]   out_after_rsp;
  fetch_entry_t head;
  fetch_entry_t push_data;

  // Requests are throttled so every in-flight fetch is guaranteed a buffer slot.
  assign ibus_req_valid_o = (state_q == RUN) && !jump_flag_i &&
                            (({1'b0, outstanding_q} + {1'b0, fifo_count}) < 3'(FIFO_DEPTH));
  assign ibus_addr_o      = pc_q;
  assign handshake        = ibus_req_valid_o && ibus_req_ready_i;

  // A response in the redirect cycle belongs to the old stream and is discarded too.
  assign drop_rsp      = ibus_rsp_valid_i && ((drop_cnt_q != 2'd0) || jump_flag_i);
  assign push          = ibus_rsp_valid_i && !drop_rsp;
  assign push_data     = '{inst: ibus_rdata_i, addr: rsp_pc_q};
  assign out_after_rsp = outstanding_q - 2'(ibus_rsp_valid_i);

  assign inst_valid_o = (fifo_count != 2'd0);
  assign pop          = inst_valid_o && !stall_i && !jump_flag_i;
  assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? head.addr : last_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      last_pc_q     <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        default: state_q <= RUN;
      endcase

      outstanding_q <= out_after_rsp + 2'(handshake);

      if (handshake) begin
        last_pc_q <= pc_q;
      end

      // Everything still in flight after this cycle's response belongs to the old stream.
      if (jump_flag_i) begin
        pc_q       <= jump_addr_i;
        rsp_pc_q   <= jump_addr_i;
        drop_cnt_q <= out_after_rsp;
      end else begin
        if (handshake) begin
          pc_q <= pc_q + INST_BYTES;
        end
        if (push) begin
          rsp_pc_q <= rsp_pc_q + INST_BYTES;
        end
        if (drop_rsp) begin
          drop_cnt_q <= drop_cnt_q - 2'd1;
        end
      end
    end
  end

  ifu_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jump_flag_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ifu.sv
// Randomized scoreboard bench for ifu with an in-order bus model and stream-level reference.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned N_CYCLES = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .jump_flag_i      (jump_flag),
    .jump_addr_i      (jump_addr),
    .stall_i          (stall),
    .ibus_req_valid_o (req_valid),
    .ibus_req_ready_i (req_ready),
    .ibus_addr_o      (req_addr),
    .ibus_rsp_valid_i (rsp_valid),
    .ibus_rdata_i     (rdata),
    .inst_o           (inst),
    .inst_addr_o      (inst_addr),
    .inst_valid_o     (inst_valid)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] mpc;
  int          buf_m;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          edges = 0;
  int          first_valid_edge = -1;
  int          consumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  // Expected consumption order is the sequential stream starting at the latest redirect target.
  function automatic void restart_stream(input logic [31:0] a);
    exp_q.delete();
    exp_next = a;
    top_up();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 1000000) edges <= edges + 1;
  end

  bit run_m, exp_rv, consume, hs, rsp_new;

  // Monitor: compare what the DUT presents this cycle, then apply the events of the coming edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      run_m = (edges >= 1);
      check1("inst_valid", inst_valid, buf_m > 0);
      if (inst_valid && buf_m > 0) begin
        check32("inst_addr", inst_addr, exp_q[0]);
        check32("inst_word", inst, mem_word(exp_q[0]));
      end
      if (inst_valid && first_valid_edge < 0) first_valid_edge = edges;
      exp_rv = run_m && !jump_flag && (pend.size() + buf_m < 2);
      check1("req_valid", req_valid, exp_rv);
      if (req_valid) check32("req_addr", req_addr, mpc);

      consume = (buf_m > 0) && !stall && !jump_flag;
      hs      = req_valid && req_ready;
      rsp_new = 1'b0;
      if (rsp_valid) begin
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL rsp_underflow: response with no accepted request (cycle %0d)", cyc);
        end else begin
          rsp_new = !pend[0].stale && !jump_flag;
          void'(pend.pop_front());
        end
      end
      if (hs) begin
        pend.push_back('{addr: mpc, stale: 1'b0, due: cyc + 1});
        mpc = mpc + 32'd4;
      end
      buf_m = buf_m - int'(consume) + int'(rsp_new);
      if (consume) begin
        void'(exp_q.pop_front());
        consumed++;
        top_up();
      end
      if (jump_flag) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        buf_m = 0;
        mpc   = jump_addr;
        restart_stream(jump_addr);
      end
    end
  end

  task automatic drive_rsp(input int prob);
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < prob) begin
      rsp_valid = 1'b1;
      rdata     = mem_word(pend[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rdata     = $urandom;
    end
  endtask

  logic [31:0] r;

  initial begin
    rst_n     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    stall     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata     = '0;
    buf_m     = 0;
    mpc       = RPC;
    restart_stream(RPC);
    repeat (3) @(posedge clk);
    #1;
    check1("rst_inst_valid", inst_valid, 1'b0);
    check32("rst_inst", inst, NOP_INST);
    check32("rst_inst_addr", inst_addr, RPC);
    check1("rst_req_valid", req_valid, 1'b0);
    rst_n = 1'b1;

    for (int c = 0; c < int'(N_CYCLES); c++) begin
      @(posedge clk);
      #1;
      cyc++;
      jump_flag = 1'b0;
      jump_addr = $urandom & 32'hFFFF_FFFC;
      if (c < 12) begin
        req_ready = 1'b1;
        stall     = 1'b0;
        drive_rsp(100);
      end else if (c < 30) begin
        req_ready = ($urandom_range(0, 99) < 70);
        stall     = ($urandom_range(0, 99) < 30);
        if (c >= 18 && c < 23) begin
          req_ready = 1'b1;
          stall     = 1'b1;
        end
        drive_rsp(70);
      end else if (c < 50) begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (c == 35) begin
          jump_flag = 1'b1;
          jump_addr = 32'h0000_0100;
        end
        if (c == 45) begin
          jump_flag = 1'b1;
          jump_addr = 32'h0000_0180;
        end
        drive_rsp((c < 35) ? 0 : 100);
      end else if (c < 70) begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (c == 55) begin
          jump_flag = 1'b1;
          jump_addr = 32'h0000_0200;
        end
        if (c == 56) begin
          jump_flag = 1'b1;
          jump_addr = 32'h0000_0300;
        end
        drive_rsp(15);
      end else if (c < 90) begin
        req_ready = 1'b1;
        stall     = ($urandom_range(0, 99) < 20);
        if (c == 72) begin
          jump_flag = 1'b1;
          jump_addr = 32'hFFFF_FFF0;
        end
        drive_rsp(100);
      end else begin
        req_ready = ($urandom_range(0, 99) < 75);
        stall     = ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 99) < 6) begin
          jump_flag = 1'b1;
          r = $urandom;
          jump_addr = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, r[3:2], 2'b00}
                                                  : {r[31:2], 2'b00};
        end
        drive_rsp(70);
      end
    end

    @(posedge clk);
    #1;
    jump_flag = 1'b0;
    rsp_valid = 1'b0;
    @(negedge clk);
    check32("first_valid_edge", 32'(first_valid_edge), 32'd3);
    checks++;
    if (consumed < 300) begin
      errors++;
      $display("FAIL progress: consumed %0d instructions, required at least 300", consumed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
